pic_priority_arbiter: RTL
=========================

Name: pic_priority_arbiter

Overview:
Clocked interrupt scheduler for the 8259 PIC. It latches IR0-IR7 requests into the IRR, resolves priority against the mask and the in-service register (ISR), and sequences the two-pulse INTA acknowledge to drive the vector. It also executes OCW2 EOI and rotation commands. It takes its configuration (mask, vector base, AEOI, LTIM) from the control logic's decoded ICW/OCW registers.

Parameters:
NUM_IR, 8, number of interrupt lines; fixed at 8 for the 8259. Encodings assume 3-bit levels.
SPURIOUS_IR, 7, level reported in the vector when INTA arrives with no eligible request.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
irq_in  input  8  raw IR0-IR7 request lines, synchronous to clk
ltim  input  1  1 = level-triggered, 0 = edge-triggered (ICW1 bit 3)
mask  input  8  interrupt mask register (OCW1); 1 = masked
aeoi  input  1  automatic EOI mode (ICW4 bit 1)
vector_base  input  5  T7-T3 vector base (ICW2[7:3])
ocw2_wr  input  1  one-cycle strobe: OCW2 command valid
ocw2_cmd  input  3  R, SL, EOI bits (OCW2[7:5])
ocw2_level  input  3  L2-L0 (OCW2[2:0])
inta_n  input  1  interrupt acknowledge, active low, synchronous to clk
int_out  output  1  INT request to the CPU
vector_out  output  8  {vector_base, level}
vector_valid  output  1  vector_out is driven during the second INTA pulse
irr  output  8  interrupt request register
isr  output  8  in-service register

Behaviour:
- Reset (rst_n low, async): irr=0, isr=0, int_out=0, vector_out=0, vector_valid=0, prio_low=7 (IR0 highest), rotate_aeoi=0, FSM=IDLE, irq_in/inta_n history registers=1 for inta_n and 0 for irq_in. Reset in any state aborts the acknowledge cycle with no ISR side effect.
- IRR, edge mode: bit sets on a 0->1 of irq_in (registered compare). Bit clears at ACK1 for the winning level, or when irq_in goes low before ACK1.
- IRR, level mode: irr = irq_in each cycle.
- Priority order: (prio_low+1) mod 8 is highest, wrapping up to prio_low, which is lowest.
- Eligible set: irr & ~mask, restricted to levels of strictly higher priority than the highest-priority set ISR bit (fully nested). Winner is the highest-priority eligible level, computed combinationally.
- inta_n edges: detected via a registered copy. fall = prev 1 and now 0; rise = prev 0 and now 1.
- FSM:
 - IDLE: eligible nonempty -> int_out=1 next cycle, go PEND.
 - PEND: eligible empty and no fall -> int_out=0, go IDLE. On fall -> ACK1.
 - ACK1 action, in the cycle of the first fall: latch the winner, or SPURIOUS_IR with a spurious flag if the eligible set is empty. Set isr[winner] unless spurious. Clear irr[winner] in edge mode. int_out=0. Go WAIT2.
 - WAIT2: on fall -> vector_out={vector_base, latched level}, vector_valid=1 next cycle, go ACK2.
 - ACK2: hold vector_valid=1 while inta_n is low. On rise -> vector_valid=0. If aeoi and not spurious, clear isr[level], and set prio_low=level when rotate_aeoi=1. Go IDLE. IDLE re-evaluates next cycle.
- An inta_n fall in IDLE is treated as ACK1 with the normal winner or spurious rules (the CPU may ack late).
- OCW2 commands, applied in the ocw2_wr cycle. "Highest ISR" means the highest-priority set bit under the current prio_low.
 - 001: non-specific EOI, clear highest ISR.
 - 011: specific EOI, clear isr[ocw2_level].
 - 101: rotate on non-specific EOI, clear highest ISR and set prio_low=that level.
 - 111: rotate on specific EOI, clear isr[level] and set prio_low=level.
 - 110: set priority, prio_low=level.
 - 100: set rotate_aeoi=1.
 - 000: set rotate_aeoi=0.
 - 010: no-op.
 - Any EOI with ISR empty changes nothing.
- Simultaneous OCW2 and ACK1 in one cycle: the EOI is evaluated on the pre-ACK ISR, and the ACK1 set is applied after it. Same-bit conflict: the set wins.
- Mask or ltim changes take effect on the next evaluation. The latched winner is never changed after ACK1.

Test Plan:
- Reset, then irq_in=0x24, mask=0, edge mode -> int_out=1. ACK1 sets isr=0x04, irr=0x20. Second pulse gives vector_out={base,3'd2}. With vector_base=5'h08 -> 0x42.
- With isr=0x04 (IR2 in service), raise IR5 -> int_out stays 0. Raise IR1 -> int_out=1 (nesting).
- Non-specific EOI (ocw2_cmd=001) with isr=0x06 -> isr=0x04. Specific EOI level 2 -> isr=0x00.
- Rotate on specific EOI level 3 with isr=0x08 -> isr=0, prio_low=3. Then irq 0x11 -> vector level 4 is acked before level 0.
- aeoi=1, rotate_aeoi=1, request IR6 -> after the second INTA rise isr=0x00 and prio_low=6. Mask IR6 in PEND before ACK1 -> ACK gives spurious vector level 7 and isr is unchanged.
- Assert rst_n=0 during WAIT2 -> all outputs zero immediately, FSM=IDLE. Pending level-mode IR3 re-raises int_out after reset release.

Source files
------------

// File: rtl/pic_priority_arbiter.sv
// 8259 interrupt scheduler: captures IR0-IR7 requests, resolves fully nested
// rotating priority against mask and ISR, sequences the two-pulse INTA
// acknowledge and executes OCW2 EOI / rotation commands.
module pic_priority_arbiter #(
  parameter int NUM_IR      = 8,
  parameter int SPURIOUS_IR = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IR-1:0] irq_in,
  input  logic              ltim,
  input  logic [NUM_IR-1:0] mask,
  input  logic              aeoi,
  input  logic [4:0]        vector_base,
  input  logic              ocw2_wr,
  input  logic [2:0]        ocw2_cmd,
  input  logic [2:0]        ocw2_level,
  input  logic              inta_n,
  output logic              int_out,
  output logic [7:0]        vector_out,
  output logic              vector_valid,
  output logic [NUM_IR-1:0] irr,
  output logic [NUM_IR-1:0] isr
);

  localparam logic [2:0] SPUR_LVL = 3'(SPURIOUS_IR);

  // ACK1 is not a resting state: it is the action taken in the cycle of the
  // first inta_n fall, leaving the FSM in WAIT2.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_WAIT2,
    ST_ACK2
  } state_t;

  // OCW2 {R, SL, EOI} command encodings.
  localparam logic [2:0] CMD_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] CMD_NS_EOI       = 3'b001;
  localparam logic [2:0] CMD_SP_EOI       = 3'b011;
  localparam logic [2:0] CMD_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] CMD_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] CMD_SET_PRIO     = 3'b110;
  localparam logic [2:0] CMD_ROT_SP_EOI   = 3'b111;

  // Rotate right so that result bit k holds v[(k + n) mod 8].
  function automatic logic [7:0] rot_right(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] d;
    d = {v, v} >> n;
    return d[7:0];
  endfunction

  // Index of the lowest set bit, or 8 when the vector is empty.
  function automatic logic [3:0] first_set(input logic [7:0] v);
    logic [3:0] r;
    r = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  state_t      state, state_nxt;
  logic        int_nxt;
  logic [7:0]  vector_nxt;
  logic        valid_nxt;
  logic [7:0]  irr_nxt, isr_nxt;
  logic [2:0]  prio_low, prio_nxt;
  logic        rotate_aeoi, rot_nxt;
  logic [2:0]  ack_level, level_nxt;
  logic        ack_spurious, spur_nxt;
  logic [7:0]  irq_prev;
  logic        inta_prev;

  logic        inta_fall, inta_rise;
  logic [2:0]  shift;
  logic [7:0]  req_rot, isr_rot, elig_rot;
  logic [3:0]  isr_first, win_first;
  logic [8:0]  above_isr;
  logic        elig_any, isr_any;
  logic [2:0]  winner, isr_top;

  assign inta_fall = inta_prev & ~inta_n;
  assign inta_rise = ~inta_prev & inta_n;

  // Priority resolution in a rotated frame where bit 0 is the highest level:
  // (prio_low + 1) maps to index 0, prio_low to index 7.
  assign shift     = prio_low + 3'd1;
  assign req_rot   = rot_right(irr & ~mask, shift);
  assign isr_rot   = rot_right(isr, shift);
  assign isr_first = first_set(isr_rot);
  assign isr_any   = |isr;
  assign isr_top   = isr_first[2:0] + shift;

  // Fully nested: only levels strictly above the highest in-service level.
  assign above_isr = (9'd1 << isr_first) - 9'd1;
  assign elig_rot  = req_rot & above_isr[7:0];
  assign elig_any  = |elig_rot;
  assign win_first = first_set(elig_rot);
  assign winner    = win_first[2:0] + shift;

  // Next-state, IRR/ISR update, OCW2 execution and acknowledge sequencing.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt  = state;
    int_nxt    = int_out;
    vector_nxt = vector_out;
    valid_nxt  = vector_valid;
    prio_nxt   = prio_low;
    rot_nxt    = rotate_aeoi;
    level_nxt  = ack_level;
    spur_nxt   = ack_spurious;
    isr_nxt    = isr;

    // Request capture: level mode mirrors the lines; edge mode sets on a
    // rising edge and drops the request once the line falls again.
    if (ltim) irr_nxt = irq_in;
    else      irr_nxt = (irr | (irq_in & ~irq_prev)) & irq_in;

    // OCW2 works on the pre-acknowledge ISR; an ACK1 set below overrides it.
    if (ocw2_wr) begin
      case (ocw2_cmd)
        CMD_NS_EOI: begin
          if (isr_any) isr_nxt[isr_top] = 1'b0;
        end
        CMD_SP_EOI: begin
          if (isr_any) isr_nxt[ocw2_level] = 1'b0;
        end
        CMD_ROT_NS_EOI: begin
          if (isr_any) begin
            isr_nxt[isr_top] = 1'b0;
            prio_nxt         = isr_top;
          end
        end
        CMD_ROT_SP_EOI: begin
          if (isr_any) begin
            isr_nxt[ocw2_level] = 1'b0;
            prio_nxt            = ocw2_level;
          end
        end
        CMD_SET_PRIO:     prio_nxt = ocw2_level;
        CMD_ROT_AEOI_SET: rot_nxt  = 1'b1;
        CMD_ROT_AEOI_CLR: rot_nxt  = 1'b0;
        default: ;
      endcase
    end

    case (state)
      ST_IDLE, ST_PEND: begin
        if (inta_fall) begin
          // ACK1: freeze the winner (or spurious level) for the whole cycle.
          if (elig_any) begin
            level_nxt       = winner;
            spur_nxt        = 1'b0;
            isr_nxt[winner] = 1'b1;
            if (!ltim) irr_nxt[winner] = 1'b0;
          end else begin
            level_nxt = SPUR_LVL;
            spur_nxt  = 1'b1;
          end
          int_nxt   = 1'b0;
          state_nxt = ST_WAIT2;
        end else if (state == ST_IDLE && elig_any) begin
          int_nxt   = 1'b1;
          state_nxt = ST_PEND;
        end else if (state == ST_PEND && !elig_any) begin
          int_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT2: begin
        if (inta_fall) begin
          vector_nxt = {vector_base, ack_level};
          valid_nxt  = 1'b1;
          state_nxt  = ST_ACK2;
        end
      end
      ST_ACK2: begin
        if (inta_rise) begin
          valid_nxt = 1'b0;
          if (aeoi && !ack_spurious) begin
            isr_nxt[ack_level] = 1'b0;
            if (rotate_aeoi) prio_nxt = ack_level;
          end
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, request/service registers and edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      int_out      <= 1'b0;
      vector_out   <= 8'h00;
      vector_valid <= 1'b0;
      irr          <= '0;
      isr          <= '0;
      prio_low     <= 3'd7;
      rotate_aeoi  <= 1'b0;
      ack_level    <= 3'd0;
      ack_spurious <= 1'b0;
      irq_prev     <= '0;
      inta_prev    <= 1'b1;
    end else begin
      // NOTE: non-blocking updates so every register samples the values
      // computed from the same pre-edge state.
      state        <= state_nxt;
      int_out      <= int_nxt;
      vector_out   <= vector_nxt;
      vector_valid <= valid_nxt;
      irr          <= irr_nxt;
      isr          <= isr_nxt;
      prio_low     <= prio_nxt;
      rotate_aeoi  <= rot_nxt;
      ack_level    <= level_nxt;
      ack_spurious <= spur_nxt;
      irq_prev     <= irq_in;
      inta_prev    <= inta_n;
    end
  end

endmodule
